// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator-side master for a word-only data memory. It accepts byte,
// halfword and word load/store requests from the processor load/store path
// and turns each one into word-aligned memory cycles. The memory can only
// write whole words, so a sub-word store is done as read-modify-write: the
// old word is read, the addressed lane is replaced, and the merged word is
// written back.
//
// Ports:
//   clk            system clock, all state changes on posedge
//   reset          asynchronous, active-low reset
//   req_valid      request present
//   req_ready      unit can accept a request (high only when idle)
//   req_we         1 = store, 0 = load
//   req_size       00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed     sign-extend sub-word loads
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   resp_valid     one-cycle completion pulse
//   resp_rdata     load result, valid with resp_valid (0 for stores/errors)
//   resp_err       misaligned, illegal size or out-of-range access
//   address_to_mem word-aligned memory address (0 when the bus is idle)
//   data_to_mem    memory write data (0 when the bus is idle)
//   write_enable   memory write strobe, high for exactly one cycle per store
//   data_from_mem  combinational memory read data
//   access_count   completed-access counter
//
// Build option:
//   MAU_ACCESS_COUNT_EN  when defined, access_count counts error-free
//                        completions and saturates at all-ones; when
//                        undefined it is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_WORDS = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [31:0]          address_to_mem,
    output logic [31:0]          data_to_mem,
    output logic                 write_enable,
    input  logic [31:0]          data_from_mem,
    output logic [CNT_WIDTH-1:0] access_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q;

    // Request fields latched at acceptance; only the parts used after
    // acceptance are kept (the word address lives in address_to_mem_q).
    logic [1:0]  req_size_q;
    logic        req_signed_q;
    logic [1:0]  req_lane_q;
    logic [31:0] req_wdata_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] address_to_mem_q;
    logic [31:0] data_to_mem_q;
    logic        write_enable_q;

    // Combinational next values
    logic        acc_err_d;
    logic [31:0] word_addr_d;
    logic [31:0] load_data_d;
    logic [31:0] merged_d;

    // Illegal size, misalignment for the size, or word index past the memory.
    function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = |addr[1:0];
            default: err = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS)) begin
            err = 1'b1;
        end
        return err;
    endfunction

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword lane of the old word with new data.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        if (size == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_HALF) begin
            r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            r = wdata;
        end
        return r;
    endfunction

    assign acc_err_d   = access_error(req_size, req_addr);
    assign word_addr_d = {req_addr[31:2], 2'b00};
    assign load_data_d = load_extract(data_from_mem, req_size_q, req_signed_q, req_lane_q);
    assign merged_d    = store_merge(data_from_mem, req_wdata_q, req_size_q, req_lane_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            req_size_q       <= 2'b00;
            req_signed_q     <= 1'b0;
            req_lane_q       <= 2'b00;
            req_wdata_q      <= 32'h0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0;
            resp_err_q       <= 1'b0;
            address_to_mem_q <= 32'h0;
            data_to_mem_q    <= 32'h0;
            write_enable_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_size_q   <= req_size;
                        req_signed_q <= req_signed;
                        req_lane_q   <= req_addr[1:0];
                        req_wdata_q  <= req_wdata;
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= acc_err_d;
                        if (acc_err_d) begin
                            // Errors skip the memory entirely.
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!req_we) begin
                            address_to_mem_q <= word_addr_d;
                            state_q          <= S_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            address_to_mem_q <= word_addr_d;
                            data_to_mem_q    <= req_wdata;
                            write_enable_q   <= 1'b1;
                            state_q          <= S_WRITE;
                        end else begin
                            address_to_mem_q <= word_addr_d;
                            state_q          <= S_READ;
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata_q     <= load_data_d;
                    resp_valid_q     <= 1'b1;
                    address_to_mem_q <= 32'h0;
                    state_q          <= S_RESP;
                end
                S_READ: begin
                    // Address stays on the bus for the write-back cycle.
                    data_to_mem_q  <= merged_d;
                    write_enable_q <= 1'b1;
                    state_q        <= S_WRITE;
                end
                S_WRITE: begin
                    write_enable_q   <= 1'b0;
                    address_to_mem_q <= 32'h0;
                    data_to_mem_q    <= 32'h0;
                    resp_valid_q     <= 1'b1;
                    state_q          <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    req_ready_q      <= 1'b1;
                    resp_valid_q     <= 1'b0;
                    write_enable_q   <= 1'b0;
                    address_to_mem_q <= 32'h0;
                    data_to_mem_q    <= 32'h0;
                    state_q          <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MAU_ACCESS_COUNT_EN
    logic [CNT_WIDTH-1:0] access_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            access_count_q <= '0;
        end else if (state_q == S_RESP && !resp_err_q && !(&access_count_q)) begin
            access_count_q <= access_count_q + CNT_WIDTH'(1);
        end
    end

    assign access_count = access_count_q;
`else
    assign access_count = '0;
`endif

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign address_to_mem = address_to_mem_q;
    assign data_to_mem    = data_to_mem_q;
    assign write_enable   = write_enable_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_unit: a bench-side word memory serves the DUT's
// bus, and a byte-lane reference model (shadow memory + shift/mask arithmetic)
// predicts every response, latency and write-back.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int MW = 64;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [31:0]   address_to_mem;
    logic [31:0]   data_to_mem;
    logic          write_enable;
    logic [31:0]   data_from_mem;
    logic [CW-1:0] access_count;

    mem_access_unit #(.MEM_WORDS(MW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .write_enable   (write_enable),
        .data_from_mem  (data_from_mem),
        .access_count   (access_count)
    );

    // Bench-side data memory
    logic [31:0] mem      [MW];
    logic [31:0] seed_mem [MW];
    logic [31:0] ref_mem  [MW];
    logic        mem_init;
    int          wr_total;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    assign data_from_mem = mem[address_to_mem[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MW; i++) mem[i] <= seed_mem[i];
        end else if (write_enable) begin
            mem[address_to_mem[7:2]] <= data_to_mem;
            wr_total <= wr_total + 1;
            wr_addr  <= address_to_mem;
            wr_data  <= data_to_mem;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_fail;
    int exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef MAU_ACCESS_COUNT_EN
        return 32'(exp_cnt);
`else
        return 32'h0;
`endif
    endfunction

    // Issue one request (caller is at a negedge), predict and check it.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] old_w, new_w, mask, exp_rdata;
        int          idx, sh, exp_lat, lat, wr0;
        bit          acc;

        idx     = int'(addr >> 2);
        sh      = int'(addr[1:0]) * 8;
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0) || (idx >= MW);
        old_w   = exp_err ? 32'h0 : ref_mem[idx];
        mask    = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        exp_rdata = 32'h0;
        new_w     = old_w;
        if (!exp_err && !we) begin
            exp_rdata = (old_w >> sh) & mask;
            if (sgn && size == 2'd0 && exp_rdata[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
            if (sgn && size == 2'd1 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
        end
        if (!exp_err && we) new_w = (old_w & ~(mask << sh)) | ((wdata & mask) << sh);
        exp_lat = exp_err ? 1 : (we && size != 2'd2) ? 3 : 2;

        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            check("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        wr0 = wr_total;
        @(negedge clk);
        // Scramble inputs after acceptance; the latched request must win.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            check("busy_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
            lat++;
        end
        check("latency",    32'(lat),            32'(exp_lat));
        check("resp_valid", 32'(resp_valid),     32'h1);
        check("resp_err",   32'(resp_err),       32'(exp_err));
        check("resp_rdata", resp_rdata,          exp_rdata);
        check("resp_ready", 32'(req_ready),      32'h0);
        check("idle_addr",  address_to_mem,      32'h0);
        check("idle_we",    32'(write_enable),   32'h0);
        check("writes",     32'(wr_total - wr0), (we && !exp_err) ? 32'h1 : 32'h0);
        if (we && !exp_err) begin
            check("wr_addr", wr_addr, {addr[31:2], 2'b00});
            check("wr_data", wr_data, new_w);
            ref_mem[idx] = new_w;
        end
        if (!exp_err) exp_cnt++;
        @(negedge clk);
        check("pulse_one", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r, idx, mism;

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        wr_total = 0;
        wr_addr  = 32'h0;
        wr_data  = 32'h0;
        mem_init = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < MW; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end

        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_ready",   32'(req_ready),    32'h1);
        check("rst_valid",   32'(resp_valid),   32'h0);
        check("rst_rdata",   resp_rdata,        32'h0);
        check("rst_err",     32'(resp_err),     32'h0);
        check("rst_addr",    address_to_mem,    32'h0);
        check("rst_wdata",   data_to_mem,       32'h0);
        check("rst_we",      32'(write_enable), 32'h0);
        check("rst_count",   32'(access_count), 32'h0);
        mem_init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Word round trip
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // Byte store read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA);
        check("rmw_word", ref_mem[8], 32'h11AA_3344);
        // Sign / zero extension
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000_F080);
        do_req(1'b0, 2'd0, 1'b1, 32'h30, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h30, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h1234_8765);
        do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
        // Errors
        do_req(1'b0, 2'd2, 1'b0, 32'h06,  32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h5555_5555);
        do_req(1'b0, 2'd3, 1'b0, 32'h04,  32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h21,  32'hFFFF);

        // Back-to-back loads with req_valid held high
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        check("b2b_busy1", 32'(req_ready), 32'h0);
        req_addr = 32'h20;
        @(negedge clk);
        check("b2b_resp1",  32'(resp_valid), 32'h1);
        check("b2b_data1",  resp_rdata,      ref_mem[4]);
        check("b2b_ready1", 32'(req_ready),  32'h0);
        @(negedge clk);
        check("b2b_idle",   32'(req_ready),  32'h1);
        @(negedge clk);
        check("b2b_busy2",  32'(req_ready),  32'h0);
        req_valid = 1'b0;
        req_addr  = 32'h30;
        @(negedge clk);
        check("b2b_resp2",  32'(resp_valid), 32'h1);
        check("b2b_data2",  resp_rdata,      ref_mem[8]);
        exp_cnt += 2;
        @(negedge clk);
        check("count_mid", 32'(access_count), exp_count());

        // Reset in the middle of a word store
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFE_BABE;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_we_high", 32'(write_enable), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_we_drop", 32'(write_enable), 32'h0);
        check("mid_ready",   32'(req_ready),    32'h1);
        check("mid_valid",   32'(resp_valid),   32'h0);
        check("mid_addr",    address_to_mem,    32'h0);
        check("mid_wdata",   data_to_mem,       32'h0);
        check("mid_count",   32'(access_count), 32'h0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_mem_kept", mem[16], ref_mem[16]);
        @(negedge clk);

        // Three good accesses plus one error
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_005A);
        do_req(1'b0, 2'd1, 1'b1, 32'h42, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h43, 32'h0);
        check("count_three", 32'(access_count), exp_count());

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r   = int'($urandom_range(0, 9));
            sz  = (r < 9) ? 2'(r % 3) : 2'd3;
            idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 70)) : int'($urandom_range(0, 63));
            ad  = {idx[29:0], 2'($urandom)};
            do_req(1'($urandom), sz, 1'($urandom), ad, $urandom);
        end
        check("count_final", 32'(access_count), exp_count());

        mism = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_final", 32'(mism), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
